// File: rtl/cnt_fnd_pkg.sv
// Shared types and segment glyphs for the counter display stage.
package cnt_fnd_pkg;

  // Binary-to-BCD converter states
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_e;

  // Common-anode glyphs, bit order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-decimal nibbles cannot come out of the converter; show them blank
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/cnt_bin2bcd.sv
// Sequential shift-add-3 (double-dabble) converter with a one-cycle result strobe.
module cnt_bin2bcd
  import cnt_fnd_pkg::*;
#(
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned N_DIGIT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CNT_W-1:0]     i_cnt,
  output logic [4*N_DIGIT-1:0] o_bcd,
  output logic                 o_bcd_vld,
  output logic                 o_busy
);

  localparam int unsigned BCD_W = 4 * N_DIGIT;
  localparam int unsigned SR_W  = BCD_W + CNT_W;
  localparam int unsigned IT_W  = $clog2(CNT_W + 1);

  conv_state_e      state_q;
  logic [CNT_W-1:0] last_q;
  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_shf;
  logic [IT_W-1:0]  iter_q;
  logic [BCD_W-1:0] bcd_q;
  logic             vld_q;
  logic             busy_q;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < int'(N_DIGIT); i++) begin
      if (sr_q[CNT_W+4*i +: 4] >= 4'd5) begin
        sr_adj[CNT_W+4*i +: 4] = sr_q[CNT_W+4*i +: 4] + 4'd3;
      end
    end
    sr_shf = {sr_adj[SR_W-2:0], 1'b0};
  end

  // Converter FSM; the result is registered on the last shift so it is
  // visible together with the strobe while the FSM sits in StDone
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      last_q  <= '0;
      sr_q    <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_cnt != last_q) begin
            last_q  <= i_cnt;
            sr_q    <= {{BCD_W{1'b0}}, i_cnt};
            iter_q  <= '0;
            state_q <= StShift;
            busy_q  <= 1'b1;
          end
        end
        StShift: begin
          sr_q   <= sr_shf;
          iter_q <= iter_q + 1'b1;
          if (iter_q == IT_W'(CNT_W - 1)) begin
            bcd_q   <= sr_shf[SR_W-1 -: BCD_W];
            vld_q   <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_bcd     = bcd_q;
  assign o_bcd_vld = vld_q;
  assign o_busy    = busy_q;

endmodule

// File: rtl/cnt_fnd_drv.sv
// Counter display driver: BCD conversion plus a multiplexed common-anode FND scanner.
module cnt_fnd_drv
  import cnt_fnd_pkg::*;
#(
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned N_DIGIT  = 2,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CNT_W-1:0]     i_cnt,
  output logic [4*N_DIGIT-1:0] o_bcd,
  output logic                 o_bcd_vld,
  output logic                 o_busy,
  output logic [N_DIGIT-1:0]   o_an,
  output logic [6:0]           o_seg
);

  localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W   = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;

  if ((10 ** N_DIGIT) <= ((2 ** CNT_W) - 1)) begin : g_bad_digits
    $error("cnt_fnd_drv: N_DIGIT too small for CNT_W");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("cnt_fnd_drv: SCAN_DIV must be at least 2");
  end

  logic [4*N_DIGIT-1:0] bcd;
  logic [PRESC_W-1:0]   presc_q;
  logic [IDX_W-1:0]     idx_q;
  logic [N_DIGIT-1:0]   an_q;
  logic [6:0]           seg_q;
  logic [N_DIGIT-1:0]   zero_hi;  // digit i and every digit above it are zero
  logic [N_DIGIT-1:0]   an_d;
  logic [6:0]           seg_d;
  logic [3:0]           nib;

  cnt_bin2bcd #(
    .CNT_W   (CNT_W),
    .N_DIGIT (N_DIGIT)
  ) u_bin2bcd (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_cnt     (i_cnt),
    .o_bcd     (bcd),
    .o_bcd_vld (o_bcd_vld),
    .o_busy    (o_busy)
  );

  // Free-running prescaler and digit index
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRESC_W'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_W'(N_DIGIT - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Anode select and glyph for the current digit, with leading-zero blanking
  always_comb begin
    zero_hi = '0;
    zero_hi[N_DIGIT-1] = (bcd[4*(N_DIGIT-1) +: 4] == 4'd0);
    for (int i = int'(N_DIGIT) - 2; i >= 0; i--) begin
      zero_hi[i] = zero_hi[i+1] && (bcd[4*i +: 4] == 4'd0);
    end
    an_d        = '1;
    an_d[idx_q] = 1'b0;
    nib         = bcd[{idx_q, 2'b00} +: 4];
    if ((BLANK_LZ != 0) && (idx_q != '0) && zero_hi[idx_q]) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_decode(nib);
    end
  end

  // Registered anode and segment drive so both switch on the same edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      an_q  <= ~N_DIGIT'(1);
      seg_q <= SEG_0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign o_bcd = bcd;
  assign o_an  = an_q;
  assign o_seg = seg_q;

endmodule

// File: tb/tb_cnt_fnd_drv.sv
// Directed self-checking bench for cnt_fnd_drv.
module tb_cnt_fnd_drv;

  logic       clk;
  logic       rst;
  logic [4:0] cnt;
  logic [7:0] bcd;
  logic       vld;
  logic       busy;
  logic [1:0] an;
  logic [6:0] seg;
  // Second instance without leading-zero blanking
  logic [7:0] bcd2;
  logic       vld2;
  logic       busy2;
  logic [1:0] an2;
  logic [6:0] seg2;

  int n_checks = 0;
  int n_errs   = 0;
  int vld_cnt  = 0;

  cnt_fnd_drv #(
    .CNT_W    (5),
    .N_DIGIT  (2),
    .SCAN_DIV (4),
    .BLANK_LZ (1)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_cnt     (cnt),
    .o_bcd     (bcd),
    .o_bcd_vld (vld),
    .o_busy    (busy),
    .o_an      (an),
    .o_seg     (seg)
  );

  cnt_fnd_drv #(
    .CNT_W    (5),
    .N_DIGIT  (2),
    .SCAN_DIV (4),
    .BLANK_LZ (0)
  ) dut_nb (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_cnt     (cnt),
    .o_bcd     (bcd2),
    .o_bcd_vld (vld2),
    .o_busy    (busy2),
    .o_an      (an2),
    .o_seg     (seg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vld === 1'b1) vld_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step until the strobe is seen or the budget runs out; n = edges taken
  task automatic wait_vld(input string tag, input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (vld !== 1'b1 && n < max_cyc);
    check_eq({tag, "_vld"}, 32'(vld), 32'd1);
  endtask

  initial begin
    int n;
    int base;
    logic [1:0] prev;
    logic [1:0] a0;
    logic [1:0] exp_an;
    int k;

    // 1: reset
    rst = 1'b1;
    cnt = 5'd0;
    tick();
    tick();
    check_eq("t1_bcd",  32'(bcd),  32'h00);
    check_eq("t1_vld",  32'(vld),  32'd0);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_an",   32'(an),   32'b10);
    check_eq("t1_seg",  32'(seg),  32'b1000000);
    rst  = 1'b0;
    base = vld_cnt;
    repeat (10) tick();
    check_eq("t1_no_pulse", 32'(vld_cnt - base), 32'd0);
    check_eq("t1_busy_idle", 32'(busy), 32'd0);

    // 2: 0 -> 31, busy for 6 cycles, result with strobe in the 6th
    cnt = 5'd31;
    for (int j = 1; j <= 7; j++) begin
      tick();
      check_eq($sformatf("t2_busy_%0d", j), 32'(busy), (j <= 6) ? 32'd1 : 32'd0);
      check_eq($sformatf("t2_vld_%0d", j),  32'(vld),  (j == 6) ? 32'd1 : 32'd0);
      check_eq($sformatf("t2_bcd_%0d", j),  32'(bcd),  (j >= 6) ? 32'h31 : 32'h00);
    end

    // 3: wrap 31 -> 0 then 0 -> 31
    base = vld_cnt;
    cnt  = 5'd0;
    wait_vld("t3a", 20, n);
    check_eq("t3a_lat", 32'(n), 32'd6);
    check_eq("t3a_bcd", 32'(bcd), 32'h00);
    tick();
    cnt = 5'd31;
    wait_vld("t3b", 20, n);
    check_eq("t3b_lat", 32'(n), 32'd6);
    check_eq("t3b_bcd", 32'(bcd), 32'h31);
    tick();
    check_eq("t3_pulses", 32'(vld_cnt - base), 32'd2);

    // 4: change during SHIFT is picked up after the first result
    base = vld_cnt;
    cnt  = 5'd5;
    tick();
    tick();
    cnt = 5'd12;
    wait_vld("t4a", 20, n);
    check_eq("t4a_lat", 32'(n), 32'd4);
    check_eq("t4a_bcd", 32'(bcd), 32'h05);
    wait_vld("t4b", 20, n);
    check_eq("t4b_lat", 32'(n), 32'd7);
    check_eq("t4b_bcd", 32'(bcd), 32'h12);
    repeat (10) tick();
    check_eq("t4_pulses", 32'(vld_cnt - base), 32'd2);
    check_eq("t4_bcd_hold", 32'(bcd), 32'h12);

    // 5: scanner with value 7
    cnt = 5'd7;
    wait_vld("t5", 20, n);
    check_eq("t5_bcd", 32'(bcd), 32'h07);
    repeat (3) tick();
    prev = an;
    k    = 0;
    do begin
      tick();
      k++;
    end while (an === prev && k < 10);
    a0 = an;
    check_eq("t5_onehot0", 32'((a0 === 2'b10) || (a0 === 2'b01)), 32'd1);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) tick();
      exp_an = (((j / 4) % 2) == 0) ? a0 : ~a0;
      check_eq($sformatf("t5_an_%0d", j),  32'(an),  32'(exp_an));
      check_eq($sformatf("t5_an2_%0d", j), 32'(an2), 32'(exp_an));
      check_eq($sformatf("t5_seg_%0d", j), 32'(seg),
               (exp_an == 2'b10) ? 32'b1111000 : 32'h7F);
      check_eq($sformatf("t5_seg2_%0d", j), 32'(seg2),
               (exp_an == 2'b10) ? 32'b1111000 : 32'b1000000);
    end

    // 6: reset in the 3rd SHIFT cycle of 0 -> 23 discards the partial result
    cnt = 5'd0;
    wait_vld("t6a", 20, n);
    check_eq("t6a_bcd", 32'(bcd), 32'h00);
    tick();
    base = vld_cnt;
    cnt  = 5'd23;
    repeat (3) tick();
    check_eq("t6_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_rst_bcd",  32'(bcd),  32'h00);
    check_eq("t6_rst_vld",  32'(vld),  32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_an",   32'(an),   32'b10);
    check_eq("t6_rst_seg",  32'(seg),  32'b1000000);
    wait_vld("t6b", 20, n);
    check_eq("t6b_lat", 32'(n), 32'd6);
    check_eq("t6b_bcd", 32'(bcd), 32'h23);
    tick();
    check_eq("t6_pulses", 32'(vld_cnt - base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
